receive_cg: RTL and testbench
=============================

Name: receive_cg

Overview:
- 1000BASE-X PCS receive path (Clause 36 style), simplified.
- Takes aligned 10-bit code groups from the synchronization stage and decodes them against the shared tablas.v code set.
- Runs the receive state machine and drives GMII-side RXD/RX_DV/RX_ER/receiving.
- Counterpart of the TRANSMIT path; a loopback of PUDR into PUDI must reproduce the transmitted frame.

Parameters:
ERR_CNT_W, 8, width of the saturating invalid-code-group counter.

Ports:
GTX_CLK  input  1  receive clock, rising edge.
mr_main_reset  input  1  asynchronous, active-high reset.
PUDI  input  10  aligned received code group, one per clock.
sync_status  input  1  1 = synchronization acquired; 0 = link failed.
RXD  output  8  decoded receive data.
RX_DV  output  1  receive data valid.
RX_ER  output  1  receive error.
receiving  output  1  carrier/packet in progress.
err_cnt  output  ERR_CNT_W  saturating count of invalid code groups seen in RX_DATA.

Behaviour:
- Reset (async, mr_main_reset=1):
  - state=LINK_FAILED, cg_q=10'b0.
  - RXD=8'h00, RX_DV=0, RX_ER=0, receiving=0, err_cnt=0.
  - Release takes effect at the next GTX_CLK edge.
- Pipeline:
  - PUDI is registered into cg_q every clock.
  - The FSM evaluates cg_q with a one-group lookahead on PUDI.
  - All outputs are registered, so latency from PUDI to RXD/RX_DV is 2 clocks.
- Decode:
  - cg_q is matched against the tablas.v 10b macros (D0.0, D1.0, D2.0, D3.0, D2.2, D16.2, D26.4, D6.5, D21.5, D5.6; K28.0–K28.7, K23.7 /R/, K27.7 /S/, K29.7 /T/, K30.7 /V/) and yields the corresponding 8b value.
  - Any other pattern is INVALID. Running disparity is not checked.
- sync_status=0 has priority in every state: next state LINK_FAILED, RX_DV=0, RX_ER=0, receiving=0.
- States (one-hot), with outputs registered on the transition edge:
  - LINK_FAILED: outputs idle. sync_status=1 -> WAIT_FOR_K.
  - WAIT_FOR_K: cg_q=K28.5 -> RX_K; else stay. RX_DV=0, RX_ER=0.
  - RX_K:
    - cg_q=D16.2 -> IDLE_D.
    - Else -> WAIT_FOR_K (configuration ordered sets are not supported).
    - receiving=0.
  - IDLE_D:
    - cg_q=K28.5 -> RX_K.
    - cg_q=/S/ -> RX_DATA with RXD=8'h55, RX_DV=1, receiving=1.
    - Otherwise (false carrier): RXD=8'h0E, RX_ER=1, RX_DV=0 for one cycle, then -> WAIT_FOR_K.
  - RX_DATA:
    - Valid data group: RXD=decoded, RX_DV=1, RX_ER=0; stay.
    - cg_q=/T/ and PUDI=/R/ -> TRR with RX_DV=0, RX_ER=0, RXD=8'h00.
    - cg_q=K28.5 (early end) -> RX_K with RX_DV=1, RX_ER=1; receiving=0 on the following cycle.
    - /V/, INVALID, other K, or /T/ not followed by /R/: RX_DV=1, RX_ER=1, RXD=8'h00; stay; err_cnt+1.
  - TRR:
    - cg_q=/R/: stay; receiving=1.
    - cg_q=K28.5 -> RX_K, receiving=0.
    - Other -> WAIT_FOR_K, receiving=0.
- err_cnt:
  - Saturates at all-ones; never wraps.
  - Increments only in RX_DATA error cases.
  - Cleared only by reset.
- Reset asserted mid-packet: outputs drop to reset values immediately (asynchronous), with no trailing RX_ER.

Test Plan:
- Reset/link-up: assert mr_main_reset mid-stream -> RXD=0, RX_DV=0, RX_ER=0, receiving=0, err_cnt=0 immediately. Release with sync_status=1 and K28.5,D16.2 repeating -> FSM cycles RX_K/IDLE_D; RX_DV stays 0.
- Good frame: idles, /S/, D3.0, D2.2, D26.4, /T/, /R/, K28.5, D16.2 -> 2 clocks after /S/ at PUDI: RX_DV=1 with RXD=55,03,42,9A. RX_DV=0 on the /T/ slot. receiving falls when K28.5 reaches cg_q. err_cnt=0.
- Error in frame: /S/, D6.5, /V/, 10'h3FF, D5.6, /T/, /R/ -> RXD=55,A6,00(ER),00(ER),C5. err_cnt=2. Clean end afterwards.
- False carrier: in IDLE_D present D21.5 instead of /S/ -> one cycle RXD=8'h0E, RX_ER=1, RX_DV=0, then WAIT_FOR_K. Recovery on the next K28.5,D16.2 pair.
- Early end and link loss: K28.5 mid-data -> one cycle RX_DV=1, RX_ER=1, then idle. Separately, drop sync_status mid-frame -> next cycle RX_DV=0, receiving=0, state LINK_FAILED.
- Saturation: ERR_CNT_W=2, stream 5 /V/ inside a frame -> err_cnt reaches 3 and holds 3.
- Loopback: TRANSMIT.PUDR -> PUDI with a 4-byte frame of table data values -> identical bytes on RXD with RX_DV framing.

Source files
------------

// File: rtl/receive_cg.sv
// -----------------------------------------------------------------------------
// receive_cg
// 1000BASE-X PCS receive path (simplified). Aligned 10-bit code groups from
// the synchronization stage are registered, decoded against the shared code
// set and walked through the receive state machine, which drives the
// GMII-side receive signals.
//
// Ports
//   GTX_CLK        in   receive clock, rising edge
//   mr_main_reset  in   asynchronous, active-high reset
//   PUDI[9:0]      in   aligned received code group (bit 9 = 'a', bit 0 = 'j')
//   sync_status    in   1 = synchronization acquired, 0 = link failed
//   RXD[7:0]       out  decoded receive data
//   RX_DV          out  receive data valid
//   RX_ER          out  receive error
//   receiving      out  carrier / packet in progress
//   err_cnt        out  saturating count of invalid groups seen inside a frame
//
// Timing: PUDI -> cg_q_r (1 clock) -> registered outputs (1 clock), so the
// data of a group appears on RXD two clocks after it is presented on PUDI.
// PUDI itself is used as a one-group lookahead to recognise /T/ followed by /R/.
// Running disparity is not checked: both disparity forms of every code group
// are accepted.
// -----------------------------------------------------------------------------
module receive_cg #(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 GTX_CLK,
    input  logic                 mr_main_reset,
    input  logic [9:0]           PUDI,
    input  logic                 sync_status,
    output logic [7:0]           RXD,
    output logic                 RX_DV,
    output logic                 RX_ER,
    output logic                 receiving,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    // One-hot receive states
    typedef enum logic [5:0] {
        LINK_FAILED = 6'b000001,
        WAIT_FOR_K  = 6'b000010,
        RX_K        = 6'b000100,
        IDLE_D      = 6'b001000,
        RX_DATA     = 6'b010000,
        TRR         = 6'b100000
    } state_t;

    // Decoded view of one code group
    typedef struct packed {
        logic       valid;
        logic       is_k;
        logic [7:0] value;
    } cg_dec_t;

    // Special code groups, both disparity forms (abcdei fghj, 'a' is the MSB)
    localparam logic [9:0] K28_5_N = 10'b0011111010;
    localparam logic [9:0] K28_5_P = 10'b1100000101;
    localparam logic [9:0] K27_7_N = 10'b1101101000;   // /S/
    localparam logic [9:0] K27_7_P = 10'b0010010111;
    localparam logic [9:0] K29_7_N = 10'b1011101000;   // /T/
    localparam logic [9:0] K29_7_P = 10'b0100010111;
    localparam logic [9:0] K23_7_N = 10'b1110101000;   // /R/
    localparam logic [9:0] K23_7_P = 10'b0001010111;

    localparam logic [7:0] D16_2_VAL = 8'h50;
    localparam logic [7:0] SFD_VAL   = 8'h55;
    localparam logic [7:0] FCAR_VAL  = 8'h0E;

    localparam logic [ERR_CNT_W-1:0] ERR_MAX = {ERR_CNT_W{1'b1}};
    localparam logic [ERR_CNT_W-1:0] ERR_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

    // 6b sub-block decode, result {known, EDCBA}
    function automatic logic [5:0] dec_6b(input logic [5:0] c6);
        logic [5:0] r;
        case (c6)
            6'b100111, 6'b011000: r = {1'b1, 5'd0};
            6'b011101, 6'b100010: r = {1'b1, 5'd1};
            6'b101101, 6'b010010: r = {1'b1, 5'd2};
            6'b110001:            r = {1'b1, 5'd3};
            6'b101001:            r = {1'b1, 5'd5};
            6'b011001:            r = {1'b1, 5'd6};
            6'b011011, 6'b100100: r = {1'b1, 5'd16};
            6'b101010:            r = {1'b1, 5'd21};
            6'b010110:            r = {1'b1, 5'd26};
            default:              r = {1'b0, 5'd0};
        endcase
        return r;
    endfunction

    // 4b sub-block decode, result {known, HGF}
    function automatic logic [3:0] dec_4b(input logic [3:0] c4);
        logic [3:0] r;
        case (c4)
            4'b1011, 4'b0100: r = {1'b1, 3'd0};
            4'b0101:          r = {1'b1, 3'd2};
            4'b1101, 4'b0010: r = {1'b1, 3'd4};
            4'b1010:          r = {1'b1, 3'd5};
            4'b0110:          r = {1'b1, 3'd6};
            default:          r = {1'b0, 3'd0};
        endcase
        return r;
    endfunction

    // Only the data values of the shared table are legal; other
    // combinations of known sub-blocks are still INVALID.
    function automatic logic is_table_data(input logic [7:0] v);
        logic r;
        case (v)
            8'h00, 8'h01, 8'h02, 8'h03, 8'h42,
            8'h50, 8'h9A, 8'hA6, 8'hB5, 8'hC5: r = 1'b1;
            default:                           r = 1'b0;
        endcase
        return r;
    endfunction

    // Full 10b -> 8b decode; special groups are matched as whole words first
    function automatic cg_dec_t decode_cg(input logic [9:0] cg);
        cg_dec_t    d;
        logic [5:0] d6;
        logic [3:0] d4;
        logic [7:0] dv;
        d6      = dec_6b(cg[9:4]);
        d4      = dec_4b(cg[3:0]);
        dv      = {d4[2:0], d6[4:0]};
        d.valid = 1'b1;
        d.is_k  = 1'b1;
        d.value = 8'h00;
        case (cg)
            10'b0011110100, 10'b1100001011: d.value = 8'h1C;  // K28.0
            10'b0011111001, 10'b1100000110: d.value = 8'h3C;  // K28.1
            10'b0011110101, 10'b1100001010: d.value = 8'h5C;  // K28.2
            10'b0011110011, 10'b1100001100: d.value = 8'h7C;  // K28.3
            10'b0011110010, 10'b1100001101: d.value = 8'h9C;  // K28.4
            10'b0011111010, 10'b1100000101: d.value = 8'hBC;  // K28.5
            10'b0011110110, 10'b1100001001: d.value = 8'hDC;  // K28.6
            10'b0011111000, 10'b1100000111: d.value = 8'hFC;  // K28.7
            10'b1110101000, 10'b0001010111: d.value = 8'hF7;  // K23.7 /R/
            10'b1101101000, 10'b0010010111: d.value = 8'hFB;  // K27.7 /S/
            10'b1011101000, 10'b0100010111: d.value = 8'hFD;  // K29.7 /T/
            10'b0111101000, 10'b1000010111: d.value = 8'hFE;  // K30.7 /V/
            default: begin
                d.is_k = 1'b0;
                if (d6[5] && d4[3] && is_table_data(dv)) begin
                    d.valid = 1'b1;
                    d.value = dv;
                end else begin
                    d.valid = 1'b0;
                    d.value = 8'h00;
                end
            end
        endcase
        return d;
    endfunction

    logic [9:0]  cg_q_r;
    state_t      state_r;
    state_t      state_nx_s;
    cg_dec_t     cg_dec_s;
    logic        cg_k285_s;
    logic        cg_d162_s;
    logic        cg_s_s;
    logic        cg_t_s;
    logic        cg_r_s;
    logic        cg_data_s;
    logic        pudi_r_s;
    logic [7:0]  rxd_nx_s;
    logic        rx_dv_nx_s;
    logic        rx_er_nx_s;
    logic        receiving_nx_s;
    logic        err_inc_s;

    // Classification of the current group and the lookahead group
    always_comb begin
        cg_dec_s  = decode_cg(cg_q_r);
        cg_k285_s = (cg_q_r == K28_5_N) || (cg_q_r == K28_5_P);
        cg_s_s    = (cg_q_r == K27_7_N) || (cg_q_r == K27_7_P);
        cg_t_s    = (cg_q_r == K29_7_N) || (cg_q_r == K29_7_P);
        cg_r_s    = (cg_q_r == K23_7_N) || (cg_q_r == K23_7_P);
        cg_data_s = cg_dec_s.valid && !cg_dec_s.is_k;
        cg_d162_s = cg_data_s && (cg_dec_s.value == D16_2_VAL);
        pudi_r_s  = (PUDI == K23_7_N) || (PUDI == K23_7_P);
    end

    // Next-state and next-output logic; outputs are registered on the
    // transition edge, so every branch sets the values seen next cycle.
    always_comb begin
        state_nx_s     = state_r;
        rxd_nx_s       = 8'h00;
        rx_dv_nx_s     = 1'b0;
        rx_er_nx_s     = 1'b0;
        receiving_nx_s = 1'b0;
        err_inc_s      = 1'b0;
        if (!sync_status) begin
            state_nx_s = LINK_FAILED;
        end else begin
            case (state_r)
                LINK_FAILED: begin
                    state_nx_s = WAIT_FOR_K;
                end
                WAIT_FOR_K: begin
                    if (cg_k285_s) begin
                        state_nx_s = RX_K;
                    end else begin
                        state_nx_s = WAIT_FOR_K;
                    end
                end
                RX_K: begin
                    // Configuration ordered sets (/C/) are not supported
                    if (cg_d162_s) begin
                        state_nx_s = IDLE_D;
                    end else begin
                        state_nx_s = WAIT_FOR_K;
                    end
                end
                IDLE_D: begin
                    if (cg_k285_s) begin
                        state_nx_s = RX_K;
                    end else if (cg_s_s) begin
                        state_nx_s     = RX_DATA;
                        rxd_nx_s       = SFD_VAL;
                        rx_dv_nx_s     = 1'b1;
                        receiving_nx_s = 1'b1;
                    end else begin
                        // False carrier: carrier is seen but no frame starts
                        state_nx_s     = WAIT_FOR_K;
                        rxd_nx_s       = FCAR_VAL;
                        rx_er_nx_s     = 1'b1;
                        receiving_nx_s = 1'b1;
                    end
                end
                RX_DATA: begin
                    receiving_nx_s = 1'b1;
                    if (cg_data_s) begin
                        rxd_nx_s   = cg_dec_s.value;
                        rx_dv_nx_s = 1'b1;
                    end else if (cg_t_s && pudi_r_s) begin
                        state_nx_s = TRR;
                    end else if (cg_k285_s) begin
                        // Early end: flag the truncated frame for one cycle
                        state_nx_s = RX_K;
                        rx_dv_nx_s = 1'b1;
                        rx_er_nx_s = 1'b1;
                    end else begin
                        rx_dv_nx_s = 1'b1;
                        rx_er_nx_s = 1'b1;
                        err_inc_s  = 1'b1;
                    end
                end
                TRR: begin
                    if (cg_r_s) begin
                        state_nx_s     = TRR;
                        receiving_nx_s = 1'b1;
                    end else if (cg_k285_s) begin
                        state_nx_s = RX_K;
                    end else begin
                        state_nx_s = WAIT_FOR_K;
                    end
                end
                default: begin
                    // Illegal one-hot encoding: fall back to the safe state
                    state_nx_s = LINK_FAILED;
                end
            endcase
        end
    end

    // Code-group input register
    always_ff @(posedge GTX_CLK or posedge mr_main_reset) begin
        if (mr_main_reset) begin
            cg_q_r <= 10'b0000000000;
        end else begin
            cg_q_r <= PUDI;
        end
    end

    // State register
    always_ff @(posedge GTX_CLK or posedge mr_main_reset) begin
        if (mr_main_reset) begin
            state_r <= LINK_FAILED;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Registered GMII-side outputs
    always_ff @(posedge GTX_CLK or posedge mr_main_reset) begin
        if (mr_main_reset) begin
            RXD       <= 8'h00;
            RX_DV     <= 1'b0;
            RX_ER     <= 1'b0;
            receiving <= 1'b0;
        end else begin
            RXD       <= rxd_nx_s;
            RX_DV     <= rx_dv_nx_s;
            RX_ER     <= rx_er_nx_s;
            receiving <= receiving_nx_s;
        end
    end

    // Saturating error counter, cleared only by reset
    always_ff @(posedge GTX_CLK or posedge mr_main_reset) begin
        if (mr_main_reset) begin
            err_cnt <= {ERR_CNT_W{1'b0}};
        end else if (err_inc_s && (err_cnt != ERR_MAX)) begin
            err_cnt <= err_cnt + ERR_ONE;
        end else begin
            err_cnt <= err_cnt;
        end
    end

endmodule

// File: tb/tb_receive_cg.sv
`timescale 1ns/1ps
module tb_receive_cg;

    // Symbol kinds used by the stimulus generator and the reference model
    localparam logic [2:0] SK_DATA  = 3'd0;
    localparam logic [2:0] SK_COMMA = 3'd1;   // K28.5
    localparam logic [2:0] SK_S     = 3'd2;
    localparam logic [2:0] SK_T     = 3'd3;
    localparam logic [2:0] SK_R     = 3'd4;
    localparam logic [2:0] SK_V     = 3'd5;
    localparam logic [2:0] SK_OTHK  = 3'd6;   // K28.y, y != 5
    localparam logic [2:0] SK_BAD   = 3'd7;

    // Reference model phases
    localparam int M_DOWN  = 0;
    localparam int M_HUNT  = 1;
    localparam int M_COMMA = 2;
    localparam int M_IDLE  = 3;
    localparam int M_FRAME = 4;
    localparam int M_TAIL  = 5;

    typedef struct packed {
        logic [2:0] kind;
        logic [7:0] val;
        logic       sy;
    } item_t;

    logic       GTX_CLK = 1'b0;
    logic       mr_main_reset;
    logic [9:0] PUDI;
    logic       sync_status;
    logic [7:0] RXD, RXD_2;
    logic       RX_DV, RX_ER, receiving;
    logic       RX_DV_2, RX_ER_2, receiving_2;
    logic [7:0] err_cnt;
    logic [1:0] err_cnt_2;

    int total = 0;
    int bad   = 0;

    item_t q[$];
    item_t prev;
    int    m_mode;
    int    m_err;
    logic [7:0] e_rxd;
    logic  e_dv, e_er, e_rcv;

    logic [7:0] dtab [0:9] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h42,
                               8'h50, 8'h9A, 8'hA6, 8'hB5, 8'hC5};

    always #5 GTX_CLK = ~GTX_CLK;

    receive_cg #(.ERR_CNT_W(8)) dut (
        .GTX_CLK(GTX_CLK), .mr_main_reset(mr_main_reset), .PUDI(PUDI),
        .sync_status(sync_status), .RXD(RXD), .RX_DV(RX_DV), .RX_ER(RX_ER),
        .receiving(receiving), .err_cnt(err_cnt)
    );

    receive_cg #(.ERR_CNT_W(2)) dut_w2 (
        .GTX_CLK(GTX_CLK), .mr_main_reset(mr_main_reset), .PUDI(PUDI),
        .sync_status(sync_status), .RXD(RXD_2), .RX_DV(RX_DV_2), .RX_ER(RX_ER_2),
        .receiving(receiving_2), .err_cnt(err_cnt_2)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Transmit-side encoder: picks either disparity form at random
    function automatic logic [9:0] enc(input item_t it, input logic pos);
        logic [5:0] b6;
        logic [3:0] b4;
        logic [9:0] w;
        b6 = 6'b000000;
        b4 = 4'b0000;
        w  = 10'b0000000000;
        case (it.kind)
            SK_DATA: begin
                case (it.val[4:0])
                    5'd0:  b6 = 6'b100111;
                    5'd1:  b6 = 6'b011101;
                    5'd2:  b6 = 6'b101101;
                    5'd3:  b6 = 6'b110001;
                    5'd5:  b6 = 6'b101001;
                    5'd6:  b6 = 6'b011001;
                    5'd16: b6 = 6'b011011;
                    5'd21: b6 = 6'b101010;
                    5'd26: b6 = 6'b010110;
                    default: b6 = 6'b000000;
                endcase
                case (it.val[7:5])
                    3'd0: b4 = 4'b1011;
                    3'd2: b4 = 4'b0101;
                    3'd4: b4 = 4'b1101;
                    3'd5: b4 = 4'b1010;
                    3'd6: b4 = 4'b0110;
                    default: b4 = 4'b0000;
                endcase
                if (pos && $countones(b6) != 3) b6 = ~b6;
                if (pos && $countones(b4) != 2) b4 = ~b4;
                w = {b6, b4};
            end
            SK_COMMA: w = 10'b0011111010;
            SK_S:     w = 10'b1101101000;
            SK_T:     w = 10'b1011101000;
            SK_R:     w = 10'b1110101000;
            SK_V:     w = 10'b0111101000;
            SK_OTHK: begin
                case (it.val[2:0])
                    3'd0: b4 = 4'b0100;
                    3'd1: b4 = 4'b1001;
                    3'd2: b4 = 4'b0101;
                    3'd3: b4 = 4'b0011;
                    3'd4: b4 = 4'b0010;
                    3'd6: b4 = 4'b0110;
                    default: b4 = 4'b1000;
                endcase
                w = {6'b001111, b4};
            end
            default: begin
                case (it.val[1:0])
                    2'd0: w = 10'h3FF;
                    2'd1: w = 10'h000;
                    default: w = 10'h155;
                endcase
            end
        endcase
        if (pos && it.kind != SK_DATA && it.kind != SK_BAD) w = ~w;
        return w;
    endfunction

    // Receive-behaviour reference at symbol level: cg = group being judged,
    // la = the group after it, sy = sync_status during that judgement.
    task automatic model_step(input item_t cg, input item_t la, input logic sy);
        int nx;
        e_rxd = 8'h00; e_dv = 1'b0; e_er = 1'b0; e_rcv = 1'b0;
        nx = m_mode;
        if (!sy) nx = M_DOWN;
        else if (m_mode == M_DOWN) nx = M_HUNT;
        else if (m_mode == M_HUNT) nx = (cg.kind == SK_COMMA) ? M_COMMA : M_HUNT;
        else if (m_mode == M_COMMA)
            nx = (cg.kind == SK_DATA && cg.val == 8'h50) ? M_IDLE : M_HUNT;
        else if (m_mode == M_IDLE) begin
            if (cg.kind == SK_COMMA) nx = M_COMMA;
            else if (cg.kind == SK_S) begin
                e_rxd = 8'h55; e_dv = 1'b1; e_rcv = 1'b1; nx = M_FRAME;
            end else begin
                e_rxd = 8'h0E; e_er = 1'b1; e_rcv = 1'b1; nx = M_HUNT;
            end
        end else if (m_mode == M_FRAME) begin
            e_rcv = 1'b1;
            if (cg.kind == SK_DATA) begin
                e_rxd = cg.val; e_dv = 1'b1;
            end else if (cg.kind == SK_T && la.kind == SK_R) nx = M_TAIL;
            else if (cg.kind == SK_COMMA) begin
                e_dv = 1'b1; e_er = 1'b1; nx = M_COMMA;
            end else begin
                e_dv = 1'b1; e_er = 1'b1; m_err++;
            end
        end else begin
            if (cg.kind == SK_R) e_rcv = 1'b1;
            else if (cg.kind == SK_COMMA) nx = M_COMMA;
            else nx = M_HUNT;
        end
        m_mode = nx;
    endtask

    task automatic model_reset();
        m_mode = M_DOWN; m_err = 0;
        e_rxd = 8'h00; e_dv = 1'b0; e_er = 1'b0; e_rcv = 1'b0;
        prev.kind = SK_BAD; prev.val = 8'h01; prev.sy = 1'b0;
    endtask

    task automatic check_outputs();
        check_val("rxd", 32'(RXD), 32'(e_rxd));
        check_val("rx_dv", 32'(RX_DV), 32'(e_dv));
        check_val("rx_er", 32'(RX_ER), 32'(e_er));
        check_val("receiving", 32'(receiving), 32'(e_rcv));
        check_val("err_cnt", 32'(err_cnt), (m_err > 255) ? 32'd255 : 32'(m_err));
        check_val("err_cnt_w2", 32'(err_cnt_2), (m_err > 3) ? 32'd3 : 32'(m_err));
        check_val("rx_dv_w2", 32'(RX_DV_2), 32'(e_dv));
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_rxd"}, 32'(RXD), 32'd0);
        check_val({tag, "_dv"}, 32'(RX_DV), 32'd0);
        check_val({tag, "_er"}, 32'(RX_ER), 32'd0);
        check_val({tag, "_rcv"}, 32'(receiving), 32'd0);
        check_val({tag, "_err"}, 32'(err_cnt), 32'd0);
        check_val({tag, "_err_w2"}, 32'(err_cnt_2), 32'd0);
    endtask

    // One clock: check what the previous groups produced, present the next
    task automatic step(input item_t it);
        check_outputs();
        PUDI = enc(it, 1'($urandom_range(0, 1)));
        sync_status = it.sy;
        model_step(prev, it, it.sy);
        prev = it;
        @(negedge GTX_CLK);
    endtask

    task automatic run_queue();
        while (q.size() > 0) step(q.pop_front());
    endtask

    task automatic push(input logic [2:0] k, input logic [7:0] v, input logic sy);
        item_t it;
        it.kind = k; it.val = v; it.sy = sy;
        q.push_back(it);
    endtask

    task automatic idles(input int n);
        repeat (n) begin
            push(SK_COMMA, 8'h00, 1'b1);
            push(SK_DATA, 8'h50, 1'b1);
        end
    endtask

    task automatic push_rand_data(input logic sy);
        push(SK_DATA, dtab[$urandom_range(0, 9)], sy);
    endtask

    task automatic push_body_sym();
        int r;
        r = $urandom_range(0, 99);
        if (r < 80) push_rand_data(1'b1);
        else if (r < 84) push(SK_V, 8'h00, 1'b1);
        else if (r < 88) push(SK_BAD, 8'($urandom_range(0, 2)), 1'b1);
        else if (r < 92) push(SK_OTHK, 8'(r % 2 == 0 ? 7 : $urandom_range(0, 4)), 1'b1);
        else if (r < 96) push(SK_R, 8'h00, 1'b1);
        else push(SK_S, 8'h00, 1'b1);
    endtask

    task automatic gen_segment();
        int r;
        int n;
        idles($urandom_range(1, 3));
        r = $urandom_range(0, 9);
        if (r < 6) begin
            push(SK_S, 8'h00, 1'b1);
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) push_body_sym();
            r = $urandom_range(0, 9);
            if (r < 7) begin
                push(SK_T, 8'h00, 1'b1);
                repeat ($urandom_range(1, 2)) push(SK_R, 8'h00, 1'b1);
            end else if (r < 9) begin
                // early end: next segment starts with K28.5
            end else begin
                push(SK_T, 8'h00, 1'b1);
                push_rand_data(1'b1);
                push(SK_T, 8'h00, 1'b1);
                push(SK_R, 8'h00, 1'b1);
            end
        end else if (r < 8) begin
            push_rand_data(1'b1);            // false carrier
        end else begin
            push(SK_S, 8'h00, 1'b1);
            push_rand_data(1'b1);
            repeat ($urandom_range(1, 3)) push_rand_data(1'b0);   // link loss
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        mr_main_reset = 1'b1;
        PUDI = 10'h000;
        sync_status = 1'b0;
        model_reset();
        repeat (3) @(negedge GTX_CLK);
        check_zero("reset");
        mr_main_reset = 1'b0;

        // link-up on idles
        idles(6);
        // good frame
        push(SK_S, 8'h00, 1'b1);
        push(SK_DATA, 8'h03, 1'b1); push(SK_DATA, 8'h42, 1'b1); push(SK_DATA, 8'h9A, 1'b1);
        push(SK_T, 8'h00, 1'b1); push(SK_R, 8'h00, 1'b1);
        idles(3);
        // errored frame
        push(SK_S, 8'h00, 1'b1);
        push(SK_DATA, 8'hA6, 1'b1); push(SK_V, 8'h00, 1'b1); push(SK_BAD, 8'h00, 1'b1);
        push(SK_DATA, 8'hC5, 1'b1);
        push(SK_T, 8'h00, 1'b1); push(SK_R, 8'h00, 1'b1);
        idles(3);
        // false carrier
        idles(1); push(SK_DATA, 8'hB5, 1'b1); idles(3);
        // early end
        idles(1); push(SK_S, 8'h00, 1'b1); push(SK_DATA, 8'h01, 1'b1); push(SK_DATA, 8'h02, 1'b1);
        idles(3);
        // link loss mid-frame
        push(SK_S, 8'h00, 1'b1); push(SK_DATA, 8'h00, 1'b1); push(SK_DATA, 8'h03, 1'b1);
        push(SK_DATA, 8'h42, 1'b0); push(SK_DATA, 8'h9A, 1'b0); push(SK_COMMA, 8'h00, 1'b0);
        idles(4);
        // saturation of the narrow counter
        push(SK_S, 8'h00, 1'b1);
        repeat (5) push(SK_V, 8'h00, 1'b1);
        push(SK_DATA, 8'h03, 1'b1); push(SK_T, 8'h00, 1'b1); push(SK_R, 8'h00, 1'b1);
        idles(3);
        // loopback-style 4-byte frame
        push(SK_S, 8'h00, 1'b1);
        repeat (4) push_rand_data(1'b1);
        push(SK_T, 8'h00, 1'b1); push(SK_R, 8'h00, 1'b1);
        idles(2);
        // frame that will be cut by a reset
        push(SK_S, 8'h00, 1'b1); push(SK_DATA, 8'h9A, 1'b1); push(SK_V, 8'h00, 1'b1);
        run_queue();

        #2 mr_main_reset = 1'b1;
        #1 check_zero("mid_reset");
        model_reset();
        repeat (2) @(negedge GTX_CLK);
        mr_main_reset = 1'b0;

        for (int s = 0; s < 60; s++) gen_segment();
        idles(3);
        run_queue();
        check_outputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
